n64_vdemux_gen: RTL and testbench

Parametrised successor of the fixed-format video demultiplexer. It sits directly behind the N64 digital video bus pins. It tracks the sync/colour word phase itself instead of taking an external `data_cnt`, and assembles a configurable number of colour channels into one packed pixel word with a valid strobe. On top of deblur handling and per-frame 15-bit mode latching, it detects malformed word groups, reports lock state and counts phase errors.

---
 rtl/n64_vdemux_gen_pkg.sv | 23 ++
 rtl/n64_vdemux_gen_if.sv | 30 +++
 rtl/n64_vdemux_phase.sv | 79 +++++++
 rtl/n64_vdemux_gen.sv | 103 ++++++++++
 tb/tb_n64_vdemux_gen.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/n64_vdemux_gen_pkg.sv
// Shared constants and vdata_o field helpers for the N64 video demultiplexer.
package n64_vdemux_gen_pkg;

    localparam int unsigned ErrCntW = 8;

    // nVSYNC is the MSB of the sync field
    function automatic int unsigned vsync_bit(input int unsigned sync_w);
        return sync_w - 1;
    endfunction

    function automatic int unsigned sync_lsb(input int unsigned color_w,
                                             input int unsigned num_ch);
        return color_w * num_ch;
    endfunction

    // Channel 0 occupies the most significant colour slot
    function automatic int unsigned ch_lsb(input int unsigned color_w,
                                           input int unsigned num_ch,
                                           input int unsigned idx);
        return (num_ch - 1 - idx) * color_w;
    endfunction

endpackage

// File: rtl/n64_vdemux_gen_if.sv
// Video bus and demux result signals; master drives the pins, slave is the demux.
interface n64_vdemux_gen_if #(
    parameter int unsigned COLOR_W = 7,
    parameter int unsigned NUM_CH  = 3,
    parameter int unsigned SYNC_W  = 4
);
    localparam int unsigned VDataW = SYNC_W + NUM_CH * COLOR_W;

    logic                nDSYNC;
    logic [COLOR_W-1:0]  D_i;
    logic                n15bit_mode_i;
    logic                ndo_deblur_i;
    logic                nblank_rgb_i;
    logic [VDataW-1:0]   vdata_o;
    logic                vdata_valid_o;
    logic                locked_o;
    logic                phase_err_o;
    logic [7:0]          err_cnt_o;

    modport master (
        output nDSYNC, D_i, n15bit_mode_i, ndo_deblur_i, nblank_rgb_i,
        input  vdata_o, vdata_valid_o, locked_o, phase_err_o, err_cnt_o
    );

    modport slave (
        input  nDSYNC, D_i, n15bit_mode_i, ndo_deblur_i, nblank_rgb_i,
        output vdata_o, vdata_valid_o, locked_o, phase_err_o, err_cnt_o
    );

endinterface

// File: rtl/n64_vdemux_phase.sv
// Word-phase tracker: phase counter, group form checks, lock state and error count.
module n64_vdemux_phase
    import n64_vdemux_gen_pkg::*;
#(
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned LOCK_GROUPS = 2,
    parameter int unsigned PhW         = $clog2(NUM_CH + 1)
) (
    input  logic               nCLK,
    input  logic               RST,
    input  logic               ndsync_i,
    output logic [PhW-1:0]     ph_o,
    output logic               cap_o,
    output logic               good_o,
    output logic               phase_err_o,
    output logic               locked_o,
    output logic [ErrCntW-1:0] err_cnt_o
);

    localparam int unsigned CntW = $clog2(LOCK_GROUPS + 1);
    localparam logic [PhW-1:0]     PhLast  = PhW'(NUM_CH);
    localparam logic [CntW-1:0]    LockCnt = CntW'(LOCK_GROUPS);
    localparam logic [ErrCntW-1:0] ErrMax  = '1;

    logic [PhW-1:0]     ph_q, ph_d;
    logic               ovr_q, ovr_d;
    logic [CntW-1:0]    good_q, good_d;
    logic               err_q, err_d;
    logic [ErrCntW-1:0] cnt_q, cnt_d;

    assign cap_o  = ndsync_i && (ph_q < PhLast);
    // Overrun words leave ph at NUM_CH, so ovr_q is needed to tell them apart
    assign good_o = (ph_q == PhLast) && !ovr_q;

    always_comb begin
        ph_d   = ph_q;
        ovr_d  = ovr_q;
        good_d = good_q;
        err_d  = 1'b0;
        cnt_d  = cnt_q;
        if (!ndsync_i) begin
            ph_d  = '0;
            ovr_d = 1'b0;
            if (good_o) begin
                if (good_q != LockCnt) good_d = good_q + 1'b1;
            end else begin
                good_d = '0;
                err_d  = 1'b1;
                if (cnt_q != ErrMax) cnt_d = cnt_q + 1'b1;
            end
        end else if (cap_o) begin
            ph_d = ph_q + 1'b1;
        end else begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(negedge nCLK) begin
        if (RST) begin
            ph_q   <= PhLast;
            ovr_q  <= 1'b0;
            good_q <= '0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            ph_q   <= ph_d;
            ovr_q  <= ovr_d;
            good_q <= good_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    assign ph_o        = ph_q;
    assign phase_err_o = err_q;
    assign locked_o    = (good_q == LockCnt);
    assign err_cnt_o   = cnt_q;

endmodule

// File: rtl/n64_vdemux_gen.sv
// N64 digital video demultiplexer: stages sync and colour words per group and
// publishes them as one packed pixel word with a valid strobe.
module n64_vdemux_gen
    import n64_vdemux_gen_pkg::*;
#(
    parameter int unsigned COLOR_W     = 7,
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned SYNC_W      = 4,
    parameter int unsigned DROP_LSB    = 2,
    parameter int unsigned SY_SLOT     = 2,
    parameter int unsigned LOCK_GROUPS = 2
) (
    input  logic             nCLK,
    input  logic             RST,
    n64_vdemux_gen_if.slave  bus
);

    localparam int unsigned PhW  = $clog2(NUM_CH + 1);
    localparam int unsigned ColW = NUM_CH * COLOR_W;
    localparam int unsigned VsB  = vsync_bit(SYNC_W);
    localparam logic [PhW-1:0]     SyCapPh  = PhW'(SY_SLOT - 1);
    localparam logic [COLOR_W-1:0] DropMask = ~COLOR_W'((1 << DROP_LSB) - 1);

    logic [PhW-1:0]     ph;
    logic               cap, good;

    logic [SYNC_W-1:0]  sy_q, sy_d;
    logic               mode_q, mode_d;
    logic [COLOR_W-1:0] stage_q [NUM_CH];
    logic [COLOR_W-1:0] stage_d [NUM_CH];
    logic [ColW-1:0]    col_q, col_d;
    logic [SYNC_W-1:0]  syo_q, syo_d;
    logic               valid_q, valid_d;
    logic [COLOR_W-1:0] word;
    logic               frame_start;

    n64_vdemux_phase #(
        .NUM_CH      (NUM_CH),
        .LOCK_GROUPS (LOCK_GROUPS),
        .PhW         (PhW)
    ) u_phase (
        .nCLK        (nCLK),
        .RST         (RST),
        .ndsync_i    (bus.nDSYNC),
        .ph_o        (ph),
        .cap_o       (cap),
        .good_o      (good),
        .phase_err_o (bus.phase_err_o),
        .locked_o    (bus.locked_o),
        .err_cnt_o   (bus.err_cnt_o)
    );

    assign frame_start = !bus.nDSYNC && sy_q[VsB] && !bus.D_i[VsB];

    always_comb begin
        word    = mode_q ? bus.D_i : (bus.D_i & DropMask);
        sy_d    = sy_q;
        mode_d  = mode_q;
        stage_d = stage_q;
        col_d   = col_q;
        syo_d   = syo_q;
        valid_d = 1'b0;
        if (!bus.nDSYNC) begin
            sy_d = bus.D_i[SYNC_W-1:0];
            if (frame_start) mode_d = bus.n15bit_mode_i;
            if (bus.ndo_deblur_i) syo_d = sy_q;
            if (good && bus.nblank_rgb_i) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    col_d[ch_lsb(COLOR_W, NUM_CH, i) +: COLOR_W] = stage_q[i];
                end
                valid_d = 1'b1;
            end
        end else if (cap) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ph == PhW'(i)) stage_d[i] = word;
            end
            // Deblur: sync is released mid-group so it lines up with the next pixel
            if (!bus.ndo_deblur_i && ph == SyCapPh) syo_d = sy_q;
        end
    end

    always_ff @(negedge nCLK) begin
        if (RST) begin
            sy_q    <= '1;
            mode_q  <= 1'b1;
            for (int i = 0; i < NUM_CH; i++) stage_q[i] <= '0;
            col_q   <= '0;
            syo_q   <= '1;
            valid_q <= 1'b0;
        end else begin
            sy_q    <= sy_d;
            mode_q  <= mode_d;
            stage_q <= stage_d;
            col_q   <= col_d;
            syo_q   <= syo_d;
            valid_q <= valid_d;
        end
    end

    assign bus.vdata_o       = {syo_q, col_q};
    assign bus.vdata_valid_o = valid_q;

endmodule

// File: tb/tb_n64_vdemux_gen.sv
// Directed bench for n64_vdemux_gen with default parameters.
module tb_n64_vdemux_gen;

    logic nCLK = 1'b0;
    logic RST  = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 nCLK = ~nCLK;

    n64_vdemux_gen_if #(.COLOR_W(7), .NUM_CH(3), .SYNC_W(4)) bus ();

    n64_vdemux_gen #(
        .COLOR_W     (7),
        .NUM_CH      (3),
        .SYNC_W      (4),
        .DROP_LSB    (2),
        .SY_SLOT     (2),
        .LOCK_GROUPS (2)
    ) dut (
        .nCLK (nCLK),
        .RST  (RST),
        .bus  (bus)
    );

    function automatic logic [31:0] pk(input logic [3:0] s, input logic [6:0] r,
                                       input logic [6:0] g, input logic [6:0] b);
        return {7'b0, s, r, g, b};
    endfunction

    task automatic step(input logic nd, input logic [6:0] d);
        bus.nDSYNC = nd;
        bus.D_i    = d;
        @(negedge nCLK);
        #1;
    endtask

    task automatic sync(input logic [3:0] s);
        step(1'b0, {3'b0, s});
    endtask

    task automatic col(input logic [6:0] c);
        step(1'b1, c);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rst(input string tag);
        chk({tag, "_vdata"}, 32'(bus.vdata_o), pk(4'hF, 7'h0, 7'h0, 7'h0));
        chk({tag, "_valid"}, 32'(bus.vdata_valid_o), 32'd0);
        chk({tag, "_locked"}, 32'(bus.locked_o), 32'd0);
        chk({tag, "_perr"}, 32'(bus.phase_err_o), 32'd0);
        chk({tag, "_ecnt"}, 32'(bus.err_cnt_o), 32'd0);
    endtask

    initial begin
        bus.nDSYNC        = 1'b1;
        bus.D_i           = '0;
        bus.n15bit_mode_i = 1'b1;
        bus.ndo_deblur_i  = 1'b1;
        bus.nblank_rgb_i  = 1'b1;

        // Reset state
        col(7'h0);
        chk_rst("reset");
        RST = 1'b0;

        // Ten full-mode groups
        sync(4'hF);
        for (int i = 0; i < 10; i++) begin
            col(7'h55);
            if (i == 0) chk("mid_valid", 32'(bus.vdata_valid_o), 32'd0);
            col(7'h2A);
            col(7'h7F);
            sync(4'hF);
            chk("full_vdata", 32'(bus.vdata_o), pk(4'hF, 7'h55, 7'h2A, 7'h7F));
            chk("full_valid", 32'(bus.vdata_valid_o), 32'd1);
            if (i >= 1) chk("full_locked", 32'(bus.locked_o), 32'd1);
        end
        chk("full_ecnt", 32'(bus.err_cnt_o), 32'd0);

        // Reduced mode latched only on an nVSYNC fall
        bus.n15bit_mode_i = 1'b0;
        col(7'h55); col(7'h2A); col(7'h7F);
        sync(4'h7);
        chk("pre15_vdata", 32'(bus.vdata_o), pk(4'hF, 7'h55, 7'h2A, 7'h7F));
        col(7'h55); col(7'h2A); col(7'h7F);
        bus.n15bit_mode_i = 1'b1;
        sync(4'h7);
        chk("red_vdata", 32'(bus.vdata_o), pk(4'h7, 7'h54, 7'h28, 7'h7C));
        col(7'h55); col(7'h2A); col(7'h7F);
        sync(4'hF);
        chk("red_hold_mode", 32'(bus.vdata_o), pk(4'h7, 7'h54, 7'h28, 7'h7C));
        col(7'h55); col(7'h2A); col(7'h7F);
        sync(4'h7);
        chk("red_last", 32'(bus.vdata_o), pk(4'hF, 7'h54, 7'h28, 7'h7C));
        col(7'h55); col(7'h2A); col(7'h7F);
        sync(4'hF);
        chk("full_again", 32'(bus.vdata_o), pk(4'h7, 7'h55, 7'h2A, 7'h7F));
        chk("full_again_lock", 32'(bus.locked_o), 32'd1);

        // Dropped B word
        col(7'h11); col(7'h22);
        sync(4'hF);
        chk("drop_perr", 32'(bus.phase_err_o), 32'd1);
        chk("drop_ecnt", 32'(bus.err_cnt_o), 32'd1);
        chk("drop_locked", 32'(bus.locked_o), 32'd0);
        chk("drop_valid", 32'(bus.vdata_valid_o), 32'd0);
        chk("drop_vdata", 32'(bus.vdata_o), pk(4'hF, 7'h55, 7'h2A, 7'h7F));
        col(7'h01);
        chk("drop_perr_once", 32'(bus.phase_err_o), 32'd0);
        col(7'h02); col(7'h03);
        sync(4'hF);
        chk("relock1_vdata", 32'(bus.vdata_o), pk(4'hF, 7'h01, 7'h02, 7'h03));
        chk("relock1_locked", 32'(bus.locked_o), 32'd0);
        col(7'h55); col(7'h2A); col(7'h7F);
        sync(4'hF);
        chk("relock2_locked", 32'(bus.locked_o), 32'd1);
        chk("relock2_ecnt", 32'(bus.err_cnt_o), 32'd1);

        // Deblur sync timing and blanking
        bus.ndo_deblur_i = 1'b0;
        col(7'h10); col(7'h20); col(7'h30);
        sync(4'h7);
        chk("db_sync_edge", 32'(bus.vdata_o), pk(4'hF, 7'h10, 7'h20, 7'h30));
        col(7'h11);
        chk("db_r_edge", 32'(bus.vdata_o[24:21]), 32'hF);
        col(7'h22);
        chk("db_g_edge", 32'(bus.vdata_o), pk(4'h7, 7'h10, 7'h20, 7'h30));
        col(7'h33);
        bus.nblank_rgb_i = 1'b0;
        sync(4'hF);
        chk("blank_vdata", 32'(bus.vdata_o), pk(4'h7, 7'h10, 7'h20, 7'h30));
        chk("blank_valid", 32'(bus.vdata_valid_o), 32'd0);
        chk("blank_locked", 32'(bus.locked_o), 32'd1);
        bus.nblank_rgb_i = 1'b1;
        bus.ndo_deblur_i = 1'b1;

        // Error counter saturation
        for (int i = 0; i < 253; i++) sync(4'hF);
        chk("sat_fe", 32'(bus.err_cnt_o), 32'hFE);
        chk("sat_locked", 32'(bus.locked_o), 32'd0);
        for (int i = 0; i < 47; i++) sync(4'hF);
        chk("sat_ff", 32'(bus.err_cnt_o), 32'hFF);
        chk("sat_perr", 32'(bus.phase_err_o), 32'd1);
        col(7'h55);
        chk("sat_hold", 32'(bus.err_cnt_o), 32'hFF);

        // Reset mid-group
        col(7'h2A);
        RST = 1'b1;
        col(7'h7F);
        chk_rst("midrst");
        RST = 1'b0;
        sync(4'hF);
        chk("post_rst_perr", 32'(bus.phase_err_o), 32'd0);
        col(7'h12); col(7'h34); col(7'h56);
        sync(4'hF);
        chk("post_rst_vdata", 32'(bus.vdata_o), pk(4'hF, 7'h12, 7'h34, 7'h56));
        chk("post_rst_valid", 32'(bus.vdata_valid_o), 32'd1);
        chk("post_rst_ecnt", 32'(bus.err_cnt_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
